asphalt_led_pio: RTL and testbench
==================================

ASPHALT_LED_PIO -- requirements
Module: asphalt_led_pio

Interface
REQ-001 Parameter WIDTH, default 8, width of out_port and of every register bit-field (1..32).
REQ-002 Parameter RESET_VALUE, default 0, value of the data register after reset.
REQ-003 Parameter PULSE_DEFAULT, default 16'd50000, reset value of the pulse-length register (1 ms at 50 MHz).
REQ-004 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Port reset_n  in  1  reset, asynchronous and active-low.
REQ-006 Port address  in  3  Avalon-MM slave word address.
REQ-007 Port chipselect  in  1  slave select; high qualifies write_n.
REQ-008 Port write_n  in  1  active-low write strobe.
REQ-009 Port writedata  in  32  write data; only bits [WIDTH-1:0] used, except register 2, which uses [15:0].
REQ-010 Port readdata  out  32  registered read data, zero-extended.
REQ-011 Port out_port  out  WIDTH  LED drive = data_reg OR pulse_reg.

Function
REQ-012 A write occurs in a cycle with chipselect=1 and write_n=0; no wait states; writes take effect at that clock edge.
REQ-013 Address 0 (DATA): write loads data_reg; read returns data_reg.
REQ-014 Address 1 (PULSE): write ORs writedata bits into pulse_reg and reloads the pulse counter; read returns pulse_reg.
REQ-015 Address 2 (PULSE_LEN): write loads the 16-bit pulse_len; read returns pulse_len; the new value applies only at the next reload.
REQ-016 Address 4 (OUTSET): write sets data_reg |= writedata; read returns 0.
REQ-017 Address 5 (OUTCLEAR): write sets data_reg &= ~writedata; read returns 0.
REQ-018 Addresses 3, 6 and 7: writes are ignored; reads return 0.
REQ-019 readdata is updated every clock from the address present, regardless of strobes, giving a fixed 1-cycle read latency.
REQ-020 A read in the same cycle as a write to the same register returns the pre-write value.
REQ-021 Pulse timer FSM has two states, IDLE (count=0, pulse_reg=0) and ACTIVE.
REQ-022 IDLE->ACTIVE on a PULSE write with nonzero bits and pulse_len != 0; count <= pulse_len.
REQ-023 In ACTIVE, count decrements by 1 per cycle; when count=1, the next edge sets count=0, clears pulse_reg and returns to IDLE, so bits stay high for exactly pulse_len cycles after the write edge.
REQ-024 A PULSE write in ACTIVE (retrigger) ORs in the new bits and reloads count to pulse_len.
REQ-025 A retrigger on the expiry edge takes priority: pulse_reg = old|new, count reloaded, and the FSM stays ACTIVE.
REQ-026 A PULSE write with writedata[WIDTH-1:0]=0, or with pulse_len=0, has no effect.
REQ-027 The counter never wraps: decrement from 0 is not possible.
REQ-028 out_port is a pure OR of registered state, so it changes only after clock edges and is glitch-free.

Reset
REQ-029 While reset_n=0, the block holds data_reg=RESET_VALUE, pulse_reg=0, count=0, pulse_len=PULSE_DEFAULT, readdata=0, FSM=IDLE and out_port=RESET_VALUE.
REQ-030 Reset asserted mid-pulse immediately clears pulse_reg and count; there is no resumption after release.

Structure
REQ-031 Shared package asphalt_pio_pkg holds the register address constants (ADDR_DATA=0, ADDR_PULSE=1, ADDR_PULSE_LEN=2, ADDR_OUTSET=4, ADDR_OUTCLEAR=5) and the pulse-counter width constant (16).
REQ-032 The pulse FSM, counter and pulse_reg are contained in one sub-module, asphalt_led_pulse_timer; the register decode and the read mux stay in the top level.

Verification
REQ-033 Reset, then write DATA=0xA5 -> out_port=0xA5 from the next cycle, and a read of address 0 returns 0x000000A5 one cycle later.
REQ-034 From DATA=0xA5, write OUTSET=0x0F then OUTCLEAR=0x81 -> out_port is 0xAF, then 0x2E; reads of addresses 4 and 5 return 0.
REQ-035 Write PULSE_LEN=4, DATA=0, then PULSE=0x03 -> out_port=0x03 for exactly 4 cycles, then 0x00; a read of address 1 returns 0 after expiry.
REQ-036 With PULSE_LEN=4, write PULSE=0x01, then PULSE=0x02 on the expiry edge -> out_port=0x03 for 4 more cycles, then 0x00.
REQ-037 Write PULSE_LEN=0, then PULSE=0xFF -> out_port stays unchanged; write address 7 = 0xFF -> no state change, and a read of address 7 returns 0.
REQ-038 Write PULSE_LEN=100, PULSE=0x10, and drop reset_n for 1 cycle at count=50 -> out_port=RESET_VALUE asynchronously, and no pulse follows release.

Source files
------------

// File: rtl/asphalt_pio_pkg.sv
// asphalt_pio_pkg: register map, pulse-counter width and pulse FSM states for the LED PIO.
package asphalt_pio_pkg;
  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_PULSE     = 3'd1;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd2;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;
  localparam int CNT_W = 16;
  typedef enum logic {IDLE, ACTIVE} pulse_state_t;
endpackage

// File: rtl/asphalt_led_pulse_timer.sv
// asphalt_led_pulse_timer: holds pulse bits high for len cycles after a trigger.
module asphalt_led_pulse_timer import asphalt_pio_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             trig,
  input  logic [WIDTH-1:0] bits,
  input  logic [CNT_W-1:0] len,
  output logic [WIDTH-1:0] pulse
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  pulse_state_t state, state_nx;
  logic [CNT_W-1:0] count, count_nx;
  logic [WIDTH-1:0] pulse_reg, pulse_nx;
  logic load, expire;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= '0;
      pulse_reg <= '0;
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      pulse_reg <= pulse_nx;
    end
  end
  // a retrigger wins over expiry, so the reload path is checked first
  always_comb begin
    load     = trig && |bits && |len;
    expire   = count <= ONE;
    state_nx = state;
    count_nx = count;
    pulse_nx = pulse_reg;
    if (load) begin
      state_nx = ACTIVE;
      count_nx = len;
      pulse_nx = pulse_reg | bits;
    end else if (state == ACTIVE) begin
      state_nx = expire ? IDLE : ACTIVE;
      count_nx = expire ? '0 : count - ONE;
      pulse_nx = expire ? '0 : pulse_reg;
    end
  end
  always_comb pulse = pulse_reg;
endmodule

// File: rtl/asphalt_led_pio.sv
// asphalt_led_pio: Avalon-MM LED PIO with set/clear aliases and a timed pulse overlay.
module asphalt_led_pio import asphalt_pio_pkg::*; #(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
  parameter logic [CNT_W-1:0] PULSE_DEFAULT = 16'd50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);
  logic wr;
  logic [WIDTH-1:0] wd, data_reg, data_nx, pulse;
  logic [CNT_W-1:0] pulse_len;
  logic [31:0] rd_mux;
  always_comb begin
    wr      = chipselect && !write_n;
    wd      = writedata[WIDTH-1:0];
    data_nx = !wr                       ? data_reg :
              address == ADDR_DATA      ? wd :
              address == ADDR_OUTSET    ? data_reg | wd :
              address == ADDR_OUTCLEAR  ? data_reg & ~wd : data_reg;
    rd_mux  = address == ADDR_DATA      ? 32'(data_reg) :
              address == ADDR_PULSE     ? 32'(pulse) :
              address == ADDR_PULSE_LEN ? 32'(pulse_len) : '0;
  end
  // readdata samples pre-edge state, so a same-cycle write shows up one read later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg  <= RESET_VALUE;
      pulse_len <= PULSE_DEFAULT;
      readdata  <= '0;
    end else begin
      data_reg  <= data_nx;
      readdata  <= rd_mux;
      if (wr && address == ADDR_PULSE_LEN) pulse_len <= writedata[CNT_W-1:0];
    end
  end
  asphalt_led_pulse_timer #(.WIDTH(WIDTH)) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .trig   (wr && address == ADDR_PULSE),
    .bits   (wd),
    .len    (pulse_len),
    .pulse  (pulse)
  );
  always_comb out_port = data_reg | pulse;
endmodule

// File: tb/tb_asphalt_led_pio.sv
// tb_asphalt_led_pio: scoreboard-driven bench for the LED PIO registers and pulse timer.
module tb_asphalt_led_pio;
  logic clk = 0, reset_n = 0, chipselect = 0, write_n = 1;
  logic [2:0] address = '0;
  logic [31:0] writedata = '0, readdata, e;
  logic [7:0] out_port;
  logic [31:0] rd_q[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  asphalt_led_pio #(.WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired before summary");
    $fatal(1);
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1; write_n = 0;
    @(posedge clk); #1;
    chipselect = 0; write_n = 1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rd_issue(input logic [2:0] a, input logic [31:0] exp_val);
    address = a; chipselect = 0; write_n = 1;
    rd_q.push_back(exp_val);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_port !== 8'h00) begin errors++; $display("FAIL reset_out_port: got %h expected 00", out_port); end
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h expected 0", readdata); end
    reset_n = 1;
    rd_issue(3'd2, 32'd50000);
    e = rd_q.pop_front(); checks++;
    if (readdata !== e) begin errors++; $display("FAIL reset_pulse_len: got %h expected %h", readdata, e); end
    rd_issue(3'd1, 32'h0);
    e = rd_q.pop_front(); checks++;
    if (readdata !== e) begin errors++; $display("FAIL reset_pulse_reg: got %h expected %h", readdata, e); end
  endtask

  task automatic test_data();
    wr(3'd0, 32'hA5);
    checks++; if (out_port !== 8'hA5) begin errors++; $display("FAIL data_out: got %h expected a5", out_port); end
    rd_issue(3'd0, 32'h0000_00A5);
    e = rd_q.pop_front(); checks++;
    if (readdata !== e) begin errors++; $display("FAIL data_read: got %h expected %h", readdata, e); end
    wr(3'd0, 32'h3C);
    checks++; if (readdata !== 32'hA5) begin errors++; $display("FAIL data_prewrite_read: got %h expected a5", readdata); end
    checks++; if (out_port !== 8'h3C) begin errors++; $display("FAIL data_overwrite: got %h expected 3c", out_port); end
    wr(3'd0, 32'hA5);
  endtask

  task automatic test_set_clear();
    wr(3'd4, 32'h0F);
    checks++; if (out_port !== 8'hAF) begin errors++; $display("FAIL outset: got %h expected af", out_port); end
    rd_issue(3'd4, 32'h0);
    e = rd_q.pop_front(); checks++;
    if (readdata !== e) begin errors++; $display("FAIL outset_read: got %h expected %h", readdata, e); end
    wr(3'd5, 32'h81);
    checks++; if (out_port !== 8'h2E) begin errors++; $display("FAIL outclear: got %h expected 2e", out_port); end
    rd_issue(3'd5, 32'h0);
    e = rd_q.pop_front(); checks++;
    if (readdata !== e) begin errors++; $display("FAIL outclear_read: got %h expected %h", readdata, e); end
    rd_issue(3'd0, 32'h2E);
    e = rd_q.pop_front(); checks++;
    if (readdata !== e) begin errors++; $display("FAIL setclr_data_read: got %h expected %h", readdata, e); end
  endtask

  task automatic test_pulse();
    wr(3'd2, 32'd4);
    rd_issue(3'd2, 32'd4);
    e = rd_q.pop_front(); checks++;
    if (readdata !== e) begin errors++; $display("FAIL pulse_len_read: got %h expected %h", readdata, e); end
    wr(3'd0, 32'h0);
    wr(3'd1, 32'h03);
    checks++; if (out_port !== 8'h03) begin errors++; $display("FAIL pulse_start: got %h expected 03", out_port); end
    for (int i = 0; i < 4; i++) begin
      rd_issue(3'd1, 32'h3);
      e = rd_q.pop_front(); checks++;
      if (readdata !== e) begin errors++; $display("FAIL pulse_read_%0d: got %h expected %h", i, readdata, e); end
      checks++;
      if (out_port !== ((i < 3) ? 8'h03 : 8'h00)) begin errors++; $display("FAIL pulse_out_%0d: got %h expected %h", i, out_port, (i < 3) ? 8'h03 : 8'h00); end
    end
    rd_issue(3'd1, 32'h0);
    e = rd_q.pop_front(); checks++;
    if (readdata !== e) begin errors++; $display("FAIL pulse_expired_read: got %h expected %h", readdata, e); end
  endtask

  task automatic test_retrigger();
    wr(3'd1, 32'h01);
    checks++; if (out_port !== 8'h01) begin errors++; $display("FAIL retrig_first: got %h expected 01", out_port); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_port !== 8'h01) begin errors++; $display("FAIL retrig_hold_%0d: got %h expected 01", i, out_port); end
    end
    wr(3'd1, 32'h02);
    checks++; if (out_port !== 8'h03) begin errors++; $display("FAIL retrig_expiry_edge: got %h expected 03", out_port); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_port !== 8'h03) begin errors++; $display("FAIL retrig_ext_%0d: got %h expected 03", i, out_port); end
    end
    tick();
    checks++; if (out_port !== 8'h00) begin errors++; $display("FAIL retrig_end: got %h expected 00", out_port); end
  endtask

  task automatic test_ignored();
    wr(3'd0, 32'h5A);
    wr(3'd2, 32'd0);
    rd_issue(3'd2, 32'h0);
    e = rd_q.pop_front(); checks++;
    if (readdata !== e) begin errors++; $display("FAIL len0_read: got %h expected %h", readdata, e); end
    wr(3'd1, 32'hFF);
    checks++; if (out_port !== 8'h5A) begin errors++; $display("FAIL len0_pulse: got %h expected 5a", out_port); end
    tick();
    checks++; if (out_port !== 8'h5A) begin errors++; $display("FAIL len0_hold: got %h expected 5a", out_port); end
    rd_issue(3'd1, 32'h0);
    e = rd_q.pop_front(); checks++;
    if (readdata !== e) begin errors++; $display("FAIL len0_pulse_read: got %h expected %h", readdata, e); end
    wr(3'd7, 32'hFF);
    wr(3'd3, 32'hFF);
    wr(3'd6, 32'hFF);
    checks++; if (out_port !== 8'h5A) begin errors++; $display("FAIL unmapped_write: got %h expected 5a", out_port); end
    for (int i = 0; i < 3; i++) begin
      logic [2:0] a;
      a = (i == 0) ? 3'd7 : (i == 1) ? 3'd3 : 3'd6;
      rd_issue(a, 32'h0);
      e = rd_q.pop_front(); checks++;
      if (readdata !== e) begin errors++; $display("FAIL unmapped_read_a%0d: got %h expected %h", a, readdata, e); end
    end
    rd_issue(3'd0, 32'h5A);
    e = rd_q.pop_front(); checks++;
    if (readdata !== e) begin errors++; $display("FAIL unmapped_data_read: got %h expected %h", readdata, e); end
    wr(3'd2, 32'd4);
    wr(3'd1, 32'h100);
    tick();
    rd_issue(3'd1, 32'h0);
    e = rd_q.pop_front(); checks++;
    if (readdata !== e) begin errors++; $display("FAIL zero_bits_pulse: got %h expected %h", readdata, e); end
  endtask

  task automatic test_reset_mid_pulse();
    wr(3'd0, 32'h22);
    wr(3'd2, 32'd100);
    wr(3'd1, 32'h10);
    checks++; if (out_port !== 8'h32) begin errors++; $display("FAIL long_pulse_start: got %h expected 32", out_port); end
    repeat (50) tick();
    checks++; if (out_port !== 8'h32) begin errors++; $display("FAIL long_pulse_mid: got %h expected 32", out_port); end
    #2 reset_n = 0;
    #1;
    checks++; if (out_port !== 8'h00) begin errors++; $display("FAIL async_reset_out: got %h expected 00", out_port); end
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL async_reset_readdata: got %h expected 0", readdata); end
    @(posedge clk); #1;
    reset_n = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (out_port !== 8'h00) begin errors++; $display("FAIL post_reset_out_%0d: got %h expected 00", i, out_port); end
    end
    rd_issue(3'd2, 32'd50000);
    e = rd_q.pop_front(); checks++;
    if (readdata !== e) begin errors++; $display("FAIL post_reset_len: got %h expected %h", readdata, e); end
    rd_issue(3'd1, 32'h0);
    e = rd_q.pop_front(); checks++;
    if (readdata !== e) begin errors++; $display("FAIL post_reset_pulse: got %h expected %h", readdata, e); end
  endtask

  initial begin
    test_reset();
    test_data();
    test_set_clear();
    test_pulse();
    test_retrigger();
    test_ignored();
    test_reset_mid_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
